amo_sequencer: RTL and testbench
================================

# amo_sequencer

Multi-cycle sequencer for RV32A instructions (LR.W, SC.W, AMO*.W) in the KianV multicycle core. Once the main control unit decodes an A-extension instruction, this block runs the datapath's `amo_*` strobes, memory handshake, register write-back and ALU source selection. It returns `done` or `fault` to the main control unit. While `busy` is high, the main control unit forwards this block's control outputs to the datapath unchanged.

## Interface

Parameters:
- `CHECK_ALIGN`, default 1: when 1, a misaligned address raises a fault; when 0, the address bits [1:0] are ignored.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request from the main control unit. Accepted only in IDLE.
- `funct5` in 5: `Instr[31:27]`.
- `addr_lo` in 2: `ALUResult[1:0]`, sampled in ADDR.
- `reserved` in 1: `amo_reserved_state_load`.
- `mem_ready` in 1: memory access complete.
- `page_fault` in 1: valid together with `mem_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, instruction retired.
- `fault` out 1: one-cycle pulse, instruction aborted.
- `fault_cause` out 4: 2 = illegal, 4 = load misaligned, 6 = store/AMO misaligned, 13 = load page fault, 15 = store/AMO page fault. Held until the next `start`.
- `mem_valid` out 1: memory request.
- `MemWrite` out 1: store strobe.
- `AdrSrc` out 1: selects the `Result` bus as memory address.
- `RegWrite` out 1: write rd.
- `ResultSrc` out 3: 0 = ALUOut/SC-result, 1 = data/temp, 5 = buffered address.
- `ALUSrcA` out 3: 2 = A1, 3 = amo temp.
- `ALUSrcB` out 2: 0 = A2, 3 = zero.
- `alu_amo_op` out 1: 0 = ADD, 1 = main control unit maps `funct5` to the AMO ALU operation.
- `amo_buffered_address` out 1.
- `amo_temp_write_operation` out 1.
- `select_ALUResult` out 1.
- `select_amo_temp` out 1.
- `amo_set_reserved_state_load` out 1.
- `amo_buffered_data` out 1.
- `muxed_Aluout_or_amo_rd_wr` out 1.

## Operation

- Reset: state IDLE, `fault_cause` = 0, every output 0.
- IDLE: on `start`, decode `funct5`.
  - Legal AMO codes: 00000 add, 00001 swap, 00100 xor, 01000 or, 01100 and, 10000 min, 10100 max, 11000 minu, 11100 maxu.
  - 00010 = LR, 00011 = SC.
  - Any other code: go to FAULT with cause 2. No other output asserts.
  - All legal codes go to ADDR.
- ADDR, 1 cycle: `ALUSrcA`=2, `ALUSrcB`=3, `alu_amo_op`=0, `amo_buffered_address`=1.
  - If `CHECK_ALIGN` and `addr_lo`≠0: go to FAULT with cause 4 (LR) or 6 (SC/AMO).
  - LR/AMO go to LOAD. SC goes to SC_STORE if `reserved`=1, otherwise SC_FAIL.
- LOAD: `mem_valid`=1, `AdrSrc`=1, `ResultSrc`=5.
  - Wait for `mem_ready`.
  - If `page_fault`: go to FAULT with cause 13 (LR) or 15 (AMO).
  - Otherwise assert `amo_temp_write_operation`=1 with `select_ALUResult`=0, so the loaded word goes into the temp register. Go to WB.
- WB, 1 cycle: `RegWrite`=1, `ResultSrc`=1, `select_amo_temp`=1.
  - LR additionally asserts `amo_set_reserved_state_load`=1 and `amo_buffered_data`=1 (sets the reservation). LR then goes to DONE.
  - AMO goes to CALC.
- CALC, 1 cycle: `ALUSrcA`=3, `ALUSrcB`=0, `alu_amo_op`=1, `amo_temp_write_operation`=1, `select_ALUResult`=1. Go to AMO_STORE.
- AMO_STORE: `mem_valid`=1, `MemWrite`=1, `AdrSrc`=1, `ResultSrc`=5, `select_amo_temp`=1.
  - On `mem_ready`: `page_fault` goes to FAULT with cause 15, otherwise go to DONE.
- SC_STORE: same as AMO_STORE with `select_amo_temp`=0, so A2 is stored.
  - On `mem_ready`: `page_fault` goes to FAULT with cause 15, otherwise go to SC_OK.
- SC_OK, 1 cycle: `RegWrite`=1, `ResultSrc`=0, `muxed_Aluout_or_amo_rd_wr`=1, `amo_buffered_data`=0, `amo_set_reserved_state_load`=1. This writes rd=0 and clears the reservation in the same cycle. Go to DONE.
- SC_FAIL, 1 cycle: `RegWrite`=1, `ResultSrc`=0, `muxed_Aluout_or_amo_rd_wr`=1, `amo_buffered_data`=1, with no reservation write. This writes rd=1. Go to SC_CLR.
- SC_CLR, 1 cycle: `amo_set_reserved_state_load`=1, `amo_buffered_data`=0. Go to DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- FAULT: `fault`=1 for 1 cycle, then IDLE. The reservation, rd and memory are not written after a fault.
- AMO instructions never modify the reservation.

## Timing

- Outputs are combinational from the state register plus `mem_ready`/`page_fault` in the memory states. The state register is updated on the `clk` rising edge.
- Latency from `start` to `done`, with W = memory wait cycles where `mem_ready` is low:
  - LR: 4+W cycles.
  - AMO: 6+W_load+W_store cycles.
  - SC success: 4+W cycles.
  - SC fail: 4 cycles.
- `mem_valid` stays high, with constant `MemWrite`/`AdrSrc`, until `mem_ready`. It drops in the cycle after `mem_ready`.
- `start` while `busy` is ignored.
- `mem_ready` outside LOAD/STORE states is ignored.
- `resetn` low mid-operation: immediate IDLE with all outputs 0, including `mem_valid`. No partial write-back or reservation update occurs after reset.

## Test plan

- LR at aligned address, `mem_ready` after 2 wait cycles:
  - `done` occurs 6 cycles after `start`.
  - Exactly one `RegWrite`, coinciding with `amo_set_reserved_state_load`=1 and `amo_buffered_data`=1.
- AMOADD (`funct5`=00000), zero-wait memory:
  - State order ADDR, LOAD, WB, CALC, AMO_STORE, DONE.
  - `RegWrite` precedes `MemWrite`.
  - `done` at cycle 6.
- SC with `reserved`=1: one store with `select_amo_temp`=0, then `RegWrite` with `amo_buffered_data`=0 and `amo_set_reserved_state_load`=1. SC with `reserved`=0: `MemWrite` never asserts, rd written with `amo_buffered_data`=1, then reservation cleared, `done` at cycle 4.
- AMOSWAP with `page_fault`=1 on the load: `fault` asserts, `fault_cause`=15, no `RegWrite`, no `MemWrite`, `busy` low on the next cycle.
- `addr_lo`=2'b10 on LR: `fault_cause`=4. `funct5`=00101: `fault_cause`=2 one cycle after `start`, with no `mem_valid`.
- `resetn` pulsed low during AMO_STORE wait: all outputs 0 immediately. A following `start` is accepted normally.

Source files
------------

// File: rtl/amo_sequencer_if.sv
// amo_sequencer_if: main-control <-> RV32A sequencer handshake and datapath strobes.
interface amo_sequencer_if;
   logic       start;
   logic [4:0] funct5;
   logic [1:0] addr_lo;
   logic       reserved;
   logic       mem_ready;
   logic       page_fault;
   logic       busy;
   logic       done;
   logic       fault;
   logic [3:0] fault_cause;
   logic       mem_valid;
   logic       MemWrite;
   logic       AdrSrc;
   logic       RegWrite;
   logic [2:0] ResultSrc;
   logic [2:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       alu_amo_op;
   logic       amo_buffered_address;
   logic       amo_temp_write_operation;
   logic       select_ALUResult;
   logic       select_amo_temp;
   logic       amo_set_reserved_state_load;
   logic       amo_buffered_data;
   logic       muxed_Aluout_or_amo_rd_wr;
   modport master (
      output start, funct5, addr_lo, reserved, mem_ready, page_fault,
      input  busy, done, fault, fault_cause, mem_valid, MemWrite, AdrSrc, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, alu_amo_op, amo_buffered_address,
             amo_temp_write_operation, select_ALUResult, select_amo_temp,
             amo_set_reserved_state_load, amo_buffered_data, muxed_Aluout_or_amo_rd_wr
   );
   modport slave (
      input  start, funct5, addr_lo, reserved, mem_ready, page_fault,
      output busy, done, fault, fault_cause, mem_valid, MemWrite, AdrSrc, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, alu_amo_op, amo_buffered_address,
             amo_temp_write_operation, select_ALUResult, select_amo_temp,
             amo_set_reserved_state_load, amo_buffered_data, muxed_Aluout_or_amo_rd_wr
   );
endinterface

// File: rtl/amo_sequencer.sv
// amo_sequencer: multi-cycle control sequencer for RV32A LR.W / SC.W / AMO*.W.
module amo_sequencer #(
   parameter int CHECK_ALIGN = 1
) (
   input logic          clk,
   input logic          resetn,
   amo_sequencer_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_LOAD, S_WB, S_CALC, S_AMO_STORE,
      S_SC_STORE, S_SC_OK, S_SC_FAIL, S_SC_CLR, S_DONE, S_FAULT
   } state_t;
   state_t     r_state;
   logic       r_lr;
   logic       r_sc;
   logic [3:0] r_cause;
   // every AMO code has funct5[1:0]==0; LR/SC/SWAP share funct5[4:2]==0
   wire logic w_legal   = bus.funct5[1:0] == 2'b00 || bus.funct5[4:2] == 3'b000;
   wire logic w_misal   = CHECK_ALIGN != 0 && bus.addr_lo != 2'b00;
   wire logic w_idle    = r_state == S_IDLE;
   wire logic w_addr    = r_state == S_ADDR;
   wire logic w_load    = r_state == S_LOAD;
   wire logic w_wb      = r_state == S_WB;
   wire logic w_calc    = r_state == S_CALC;
   wire logic w_amo_st  = r_state == S_AMO_STORE;
   wire logic w_store   = w_amo_st || r_state == S_SC_STORE;
   wire logic w_mem     = w_load || w_store;
   wire logic w_sc_ok   = r_state == S_SC_OK;
   wire logic w_sc_fail = r_state == S_SC_FAIL;
   wire logic w_sc_clr  = r_state == S_SC_CLR;
   wire logic w_lr_wb   = w_wb && r_lr;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_lr    <= 1'b0;
         r_sc    <= 1'b0;
         r_cause <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_lr    <= bus.funct5 == 5'b00010;
               r_sc    <= bus.funct5 == 5'b00011;
               r_cause <= w_legal ? 4'd0 : 4'd2;
               r_state <= w_legal ? S_ADDR : S_FAULT;
            end
            S_ADDR: if (w_misal) begin
               r_cause <= r_lr ? 4'd4 : 4'd6;
               r_state <= S_FAULT;
            end else
               r_state <= !r_sc ? S_LOAD : bus.reserved ? S_SC_STORE : S_SC_FAIL;
            S_LOAD: if (bus.mem_ready) begin
               if (bus.page_fault) r_cause <= r_lr ? 4'd13 : 4'd15;
               r_state <= bus.page_fault ? S_FAULT : S_WB;
            end
            S_WB:   r_state <= r_lr ? S_DONE : S_CALC;
            S_CALC: r_state <= S_AMO_STORE;
            S_AMO_STORE, S_SC_STORE: if (bus.mem_ready) begin
               if (bus.page_fault) r_cause <= 4'd15;
               r_state <= bus.page_fault ? S_FAULT : w_amo_st ? S_DONE : S_SC_OK;
            end
            S_SC_OK:   r_state <= S_DONE;
            S_SC_FAIL: r_state <= S_SC_CLR;
            S_SC_CLR:  r_state <= S_DONE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end
   assign bus.busy        = !w_idle;
   assign bus.done        = r_state == S_DONE;
   assign bus.fault       = r_state == S_FAULT;
   assign bus.fault_cause = r_cause;
   assign bus.mem_valid   = w_mem;
   assign bus.MemWrite    = w_store;
   assign bus.AdrSrc      = w_mem;
   assign bus.RegWrite    = w_wb || w_sc_ok || w_sc_fail;
   assign bus.ResultSrc   = w_mem ? 3'd5 : w_wb ? 3'd1 : 3'd0;
   assign bus.ALUSrcA     = w_addr ? 3'd2 : w_calc ? 3'd3 : 3'd0;
   assign bus.ALUSrcB     = w_addr ? 2'd3 : 2'd0;
   assign bus.alu_amo_op  = w_calc;
   assign bus.amo_buffered_address = w_addr;
   // loaded word is captured into temp on the completing load beat only
   assign bus.amo_temp_write_operation    = w_calc || (w_load && bus.mem_ready && !bus.page_fault);
   assign bus.select_ALUResult            = w_calc;
   assign bus.select_amo_temp             = w_wb || w_amo_st;
   assign bus.amo_set_reserved_state_load = w_lr_wb || w_sc_ok || w_sc_clr;
   assign bus.amo_buffered_data           = w_lr_wb || w_sc_fail;
   assign bus.muxed_Aluout_or_amo_rd_wr   = w_sc_ok || w_sc_fail;
endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: table, hand-sequenced and random checks of amo_sequencer against an outcome model.
module tb_amo_sequencer;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   amo_sequencer_if bus();
   amo_sequencer #(.CHECK_ALIGN(1)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;

   typedef struct { logic [4:0] f; logic [1:0] a; bit res; int w0; int w1; bit pf0; bit pf1; } op_t;
   typedef struct { int ok; int cause; int lat; int rw; int mw; int acc; int res; int viol; } res_t;
   typedef struct { op_t op; res_t exp; } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   tb_res;
   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int any_out();
      return int'(|{bus.busy, bus.done, bus.fault, bus.fault_cause, bus.mem_valid, bus.MemWrite,
                    bus.AdrSrc, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.alu_amo_op,
                    bus.amo_buffered_address, bus.amo_temp_write_operation, bus.select_ALUResult,
                    bus.select_amo_temp, bus.amo_set_reserved_state_load, bus.amo_buffered_data,
                    bus.muxed_Aluout_or_amo_rd_wr});
   endfunction

   function automatic int sig();
      return int'({bus.mem_valid, bus.MemWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                   bus.alu_amo_op, bus.amo_buffered_address, bus.amo_temp_write_operation,
                   bus.select_ALUResult, bus.select_amo_temp, bus.done});
   endfunction

   function automatic int mk(bit mv, bit mw, bit rw, logic [2:0] rs, logic [2:0] sa, logic [1:0] sb,
                             bit op, bit ba, bit tw, bit sl, bit st, bit d);
      return int'({mv, mw, rw, rs, sa, sb, op, ba, tw, sl, st, d});
   endfunction

   // outcome of one instruction from the architectural rules and latency formulas
   function automatic res_t model(input op_t o);
      res_t e;
      bit legal = o.f inside {5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                              5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b00010, 5'b00011};
      bit lr = o.f == 5'b00010;
      bit sc = o.f == 5'b00011;
      e.ok = 0; e.cause = 0; e.lat = 0; e.rw = 0; e.mw = 0; e.acc = 0; e.res = o.res; e.viol = 0;
      if (!legal) begin e.cause = 2; e.lat = 1; end
      else if (o.a != 0) begin e.cause = lr ? 4 : 6; e.lat = 2; end
      else if (lr) begin
         e.acc = 1;
         if (o.pf0) begin e.cause = 13; e.lat = 3 + o.w0; end
         else begin e.ok = 1; e.lat = 4 + o.w0; e.rw = 1; e.res = 1; end
      end else if (sc) begin
         if (!o.res) begin e.ok = 1; e.lat = 4; e.rw = 1; e.res = 0; end
         else begin
            e.acc = 1;
            if (o.pf0) begin e.cause = 15; e.lat = 3 + o.w0; end
            else begin e.ok = 1; e.lat = 4 + o.w0; e.rw = 1; e.mw = 1; e.res = 0; end
         end
      end else if (o.pf0) begin e.cause = 15; e.lat = 3 + o.w0; e.acc = 1; end
      else begin
         e.acc = 2; e.rw = 1; e.lat = 6 + o.w0 + o.w1;
         if (o.pf1) e.cause = 15;
         else begin e.ok = 1; e.mw = 1; end
      end
      return e;
   endfunction

   task automatic run_op(input op_t o, output res_t r);
      int wc = 0;
      int acc = 0;
      bit fin = 0;
      bit prev_hs = 0;
      r.ok = 0; r.cause = -1; r.lat = -1; r.rw = 0; r.mw = 0; r.acc = 0; r.res = 0; r.viol = 0;
      tb_res = o.res;
      @(negedge clk);
      bus.funct5 = o.f; bus.addr_lo = o.a; bus.reserved = o.res; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 100 && !fin; c++) begin
         bus.mem_ready = 1'b0;
         bus.page_fault = 1'b0;
         if (bus.mem_valid) begin
            if (wc == (acc == 0 ? o.w0 : o.w1)) begin
               bus.mem_ready = 1'b1;
               bus.page_fault = acc == 0 ? o.pf0 : o.pf1;
            end else wc++;
         end
         #1;
         if (prev_hs && bus.mem_valid) r.viol++;
         prev_hs = bus.mem_valid && bus.mem_ready;
         if (bus.RegWrite) r.rw++;
         if (bus.MemWrite && bus.mem_ready && !bus.page_fault) r.mw++;
         if (prev_hs) begin acc++; wc = 0; end
         if (bus.amo_set_reserved_state_load) tb_res = bus.amo_buffered_data;
         if (bus.done || bus.fault) begin
            fin = 1; r.ok = int'(bus.done); r.cause = int'(bus.fault_cause); r.lat = c;
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      bus.page_fault = 1'b0;
      r.acc = acc;
      r.res = int'(tb_res);
   endtask

   task automatic check_op(input string t, input op_t o, input res_t e);
      res_t r;
      run_op(o, r);
      chk({t, " done"}, r.ok, e.ok);
      chk({t, " cause"}, r.cause, e.cause);
      chk({t, " latency"}, r.lat, e.lat);
      chk({t, " regwrites"}, r.rw, e.rw);
      chk({t, " memwrites"}, r.mw, e.mw);
      chk({t, " accesses"}, r.acc, e.acc);
      chk({t, " reservation"}, r.res, e.res);
      chk({t, " valid after ready"}, r.viol, 0);
      chk({t, " busy after"}, int'(bus.busy), 0);
      chk({t, " cause held"}, int'(bus.fault_cause), e.cause);
   endtask

   task automatic add(input logic [4:0] f, input logic [1:0] a, input bit rs, input int w0, input int w1,
                      input bit pf0, input bit pf1, input int ok, input int cause, input int lat,
                      input int rw, input int mw, input int acc, input int eres);
      vec_t v;
      v.op.f = f; v.op.a = a; v.op.res = rs; v.op.w0 = w0; v.op.w1 = w1; v.op.pf0 = pf0; v.op.pf1 = pf1;
      v.exp.ok = ok; v.exp.cause = cause; v.exp.lat = lat; v.exp.rw = rw; v.exp.mw = mw;
      v.exp.acc = acc; v.exp.res = eres; v.exp.viol = 0;
      tbl.push_back(v);
   endtask

   initial begin
      logic [4:0] codes [11] = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28, 5'd2, 5'd3};
      int exp_sig [6];
      bit seen;
      op_t o;
      bus.start = 1'b0; bus.funct5 = 5'd0; bus.addr_lo = 2'd0; bus.reserved = 1'b0;
      bus.mem_ready = 1'b1; bus.page_fault = 1'b0;
      //  f       a  rs w0 w1 pf0 pf1  ok cause lat rw mw acc res
      add(5'd2,  2'd0, 0, 2, 0, 0, 0,   1,  0,  6,  1, 0, 1, 1);
      add(5'd0,  2'd0, 1, 0, 0, 0, 0,   1,  0,  6,  1, 1, 2, 1);
      add(5'd3,  2'd0, 1, 0, 0, 0, 0,   1,  0,  4,  1, 1, 1, 0);
      add(5'd3,  2'd0, 0, 0, 0, 0, 0,   1,  0,  4,  1, 0, 0, 0);
      add(5'd1,  2'd0, 1, 0, 0, 1, 0,   0, 15,  3,  0, 0, 1, 1);
      add(5'd2,  2'd2, 0, 0, 0, 0, 0,   0,  4,  2,  0, 0, 0, 0);
      add(5'd5,  2'd0, 1, 0, 0, 0, 0,   0,  2,  1,  0, 0, 0, 1);
      add(5'd28, 2'd0, 0, 1, 3, 0, 1,   0, 15, 10,  1, 0, 2, 0);
      add(5'd3,  2'd1, 1, 0, 0, 0, 0,   0,  6,  2,  0, 0, 0, 1);
      add(5'd2,  2'd0, 0, 1, 0, 1, 0,   0, 13,  4,  0, 0, 1, 0);
      add(5'd3,  2'd0, 1, 2, 0, 1, 0,   0, 15,  5,  0, 0, 1, 1);
      add(5'd6,  2'd0, 0, 0, 0, 0, 0,   0,  2,  1,  0, 0, 0, 0);

      repeat (2) @(negedge clk);
      chk("reset outputs", any_out(), 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("idle ignores mem_ready", any_out(), 0);
      bus.mem_ready = 1'b0;

      foreach (tbl[i]) check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp);

      // AMOADD with memory always ready, plus a start pulse while busy
      exp_sig[0] = mk(0, 0, 0, 3'd0, 3'd2, 2'd3, 0, 1, 0, 0, 0, 0);
      exp_sig[1] = mk(1, 0, 0, 3'd5, 3'd0, 2'd0, 0, 0, 1, 0, 0, 0);
      exp_sig[2] = mk(0, 0, 1, 3'd1, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0);
      exp_sig[3] = mk(0, 0, 0, 3'd0, 3'd3, 2'd0, 1, 0, 1, 1, 0, 0);
      exp_sig[4] = mk(1, 1, 0, 3'd5, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0);
      exp_sig[5] = mk(0, 0, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      bus.funct5 = 5'd0; bus.addr_lo = 2'd0; bus.start = 1'b1; bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         bus.start = c == 3; bus.funct5 = c == 3 ? 5'b00101 : 5'd0;
         #1;
         chk($sformatf("amoadd cycle%0d", c), sig(), exp_sig[c-1]);
         chk($sformatf("amoadd nofault%0d", c), int'(bus.fault), 0);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("amoadd back idle", int'(bus.busy), 0);

      // reset pulse while the AMO store is waiting on memory
      @(negedge clk);
      bus.funct5 = 5'd0; bus.start = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         bus.mem_ready = bus.mem_valid && !bus.MemWrite;
         #1;
         seen = bus.MemWrite;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      chk("store wait reached", int'(seen), 1);
      chk("store still waiting", int'(bus.MemWrite), 1);
      resetn = 1'b0;
      #1;
      chk("mid reset outputs", any_out(), 0);
      @(negedge clk);
      resetn = 1'b1;
      o.f = 5'd2; o.a = 2'd0; o.res = 0; o.w0 = 0; o.w1 = 0; o.pf0 = 0; o.pf1 = 0;
      check_op("after reset LR", o, model(o));

      for (int i = 0; i < 150; i++) begin
         o.f   = $urandom_range(0, 9) < 7 ? codes[$urandom_range(0, 10)] : 5'($urandom);
         o.a   = $urandom_range(0, 4) == 0 ? 2'($urandom) : 2'd0;
         o.res = 1'($urandom);
         o.w0  = $urandom_range(0, 3);
         o.w1  = $urandom_range(0, 3);
         o.pf0 = $urandom_range(0, 5) == 0;
         o.pf1 = $urandom_range(0, 5) == 0;
         check_op($sformatf("rnd%0d", i), o, model(o));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
